// File: rtl/imm_encoder_pkg.sv
// Shared RV32I encoding constants and format classification for imm_encoder.
// Optional range/alignment checking is selected with the IMM_CHECK_EN macro.
package imm_encoder_pkg;

  localparam int INST_WIDTH = 32;
  localparam int OPCODE     = 7;

  localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OPCODE-1:0] OP_ALUI   = 7'b0010011;
  localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE-1:0] OP_ALU    = 7'b0110011;
  localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } imm_fmt_e;

  function automatic imm_fmt_e fmt_of(input logic [OPCODE-1:0] op);
    imm_fmt_e f;
    case (op)
      OP_ALU:                                        f = FMT_R;
      OP_ALUI, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: f = FMT_I;
      OP_STORE:                                      f = FMT_S;
      OP_BRANCH:                                     f = FMT_B;
      OP_LUI, OP_AUIPC:                              f = FMT_U;
      OP_JAL:                                        f = FMT_J;
      default:                                       f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_encoder_fifo.sv
// Generic valid/ready FIFO; ready_o depends only on the fill count, never on ready_i.
module imm_encoder_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  assign ready_o = (count != DEPTH[AW:0]);
  assign valid_o = (count != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Packs RV32I fields plus a signed immediate into an instruction word, buffered by a FIFO.
// Define IMM_CHECK_EN to flag out-of-range or misaligned immediates on err_o.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int                     FIFO_DEPTH = 2,
  parameter logic [INST_WIDTH-1:0]  NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [OPCODE-1:0]     opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [INST_WIDTH-1:0] imm_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  err_o
);

  imm_fmt_e              fmt;
  logic                  shamt;
  logic [INST_WIDTH-1:0] inst;
  logic                  range_err;
  logic                  err;

  assign fmt   = fmt_of(opcode_i);
  // Shift-immediates reuse funct7 as the top field and carry a 5-bit shift amount.
  assign shamt = (opcode_i == OP_ALUI) && (funct3_i == 3'b001 || funct3_i == 3'b101);

  always_comb begin
    inst = NOP_INST;
    case (fmt)
      FMT_R: inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: inst = shamt ? {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i}
                          : {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: inst = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: inst = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: inst = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: inst = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: inst = NOP_INST;
    endcase
  end

`ifdef IMM_CHECK_EN
  logic signed [INST_WIDTH-1:0] simm;
  assign simm = $signed(imm_i);

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I:   range_err = shamt ? (simm < 0 || simm > 31)
                                 : (simm < -2048 || simm > 2047);
      FMT_S:   range_err = (simm < -2048 || simm > 2047);
      FMT_B:   range_err = (simm < -4096 || simm > 4094 || imm_i[0]);
      FMT_U:   range_err = (imm_i[11:0] != 12'h000);
      FMT_J:   range_err = (simm < -1048576 || simm > 1048574 || imm_i[0]);
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign err = (fmt == FMT_BAD) | range_err;

  imm_encoder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INST_WIDTH + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  ({err, inst}),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  ({err_o, inst_o})
  );

endmodule
